mult32x32_fast_ctrl: RTL and testbench

Sequencing controller for the 32x32 fast multiplier arithmetic unit. Given a start pulse, it drives the unit's operand-half selects, shifter select and product-register controls to accumulate the 16x16 partial products into the 64-bit product. It skips the partial products whose operand most-significant 16-bit word (MSW) is zero, then reports completion. It sits between the requesting logic and the arithmetic unit; together they form the fast multiplier top level.

---
 rtl/mult32x32_fast_ctrl.sv | 106 ++++++++++
 tb/tb_mult32x32_fast_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_fast_ctrl.sv
// Sequencer for the 32x32 fast multiplier: steps the 16x16 partial products and
// skips those whose operand MSW is zero when MULT_FAST_SKIP_EN is defined.
module mult32x32_fast_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msw_is_0,
  input  logic       b_msw_is_0,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod,
  output logic       busy,
  output logic       done,
  output logic [2:0] pp_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P00  = 3'd1,
    P01  = 3'd2,
    P10  = 3'd3,
    P11  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   az;
  logic   bz;
  logic   accept;

  assign accept = (state == IDLE) && start;

  // Gated by reset so the clear stays low while the block is held in reset.
  assign clr_prod = reset && accept;

`ifdef MULT_FAST_SKIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      az <= 1'b0;
      bz <= 1'b0;
    end else if (accept) begin
      az <= a_msw_is_0;
      bz <= b_msw_is_0;
    end
  end
`else
  logic unused_msw;
  assign az         = 1'b0;
  assign bz         = 1'b0;
  assign unused_msw = a_msw_is_0 ^ b_msw_is_0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = P00;
      P00: begin
        if (!bz)      state_nxt = P01;
        else if (!az) state_nxt = P10;
        else          state_nxt = DONE;
      end
      P01:     state_nxt = az ? DONE : P10;
      P10:     state_nxt = bz ? DONE : P11;
      P11:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      shift_sel <= 2'd0;
      upd_prod  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pp_count  <= 3'd0;
    end else begin
      state     <= state_nxt;
      a_sel     <= (state_nxt == P10) || (state_nxt == P11);
      b_sel     <= (state_nxt == P01) || (state_nxt == P11);
      if (state_nxt == P11)
        shift_sel <= 2'd2;
      else if ((state_nxt == P01) || (state_nxt == P10))
        shift_sel <= 2'd1;
      else
        shift_sel <= 2'd0;
      upd_prod  <= (state_nxt == P00) || (state_nxt == P01) ||
                   (state_nxt == P10) || (state_nxt == P11);
      busy      <= (state_nxt == P00) || (state_nxt == P01) ||
                   (state_nxt == P10) || (state_nxt == P11);
      done      <= (state_nxt == DONE);
      if (accept)
        pp_count <= 3'd0;
      else if (upd_prod && (pp_count != 3'd4))
        pp_count <= pp_count + 3'd1;
    end
  end

endmodule

// File: tb/tb_mult32x32_fast_ctrl.sv
// Directed bench for mult32x32_fast_ctrl with a behavioural model of the
// arithmetic unit's product register; honours MULT_FAST_SKIP_EN.
module tb_mult32x32_fast_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        a_msw_is_0;
  logic        b_msw_is_0;
  logic        a_sel;
  logic        b_sel;
  logic [1:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic        busy;
  logic        done;
  logic [2:0]  pp_count;

  logic [63:0] prod;
  logic [31:0] pp;
  logic [7:0]  obs;
  int          checks = 0;
  int          passed = 0;

  mult32x32_fast_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_msw_is_0 (a_msw_is_0),
    .b_msw_is_0 (b_msw_is_0),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .shift_sel  (shift_sel),
    .upd_prod   (upd_prod),
    .clr_prod   (clr_prod),
    .busy       (busy),
    .done       (done),
    .pp_count   (pp_count)
  );

  always #5 clk = ~clk;

  assign a_msw_is_0 = (op_a[31:16] == 16'd0);
  assign b_msw_is_0 = (op_b[31:16] == 16'd0);
  assign pp  = {16'd0, (a_sel ? op_a[31:16] : op_a[15:0])} *
               {16'd0, (b_sel ? op_b[31:16] : op_b[15:0])};
  assign obs = {a_sel, b_sel, shift_sel, upd_prod, busy, done, clr_prod};

  // Product register of the arithmetic unit.
  always @(posedge clk or negedge reset) begin
    if (!reset)
      prod <= 64'd0;
    else if (clr_prod)
      prod <= 64'd0;
    else if (upd_prod) begin
      case (shift_sel)
        2'd1:    prod <= prod + ({32'd0, pp} << 16);
        2'd2:    prod <= prod + ({32'd0, pp} << 32);
        default: prod <= prod + {32'd0, pp};
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // seq holds up to four {a_sel,b_sel,shift_sel} nibbles, first step in the top nibble.
  // poke re-asserts start for one cycle at that cycle index (0 = never).
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [15:0] seq, input logic [63:0] exp_prod,
                        input int poke);
    logic [7:0] exp_o;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h01) $display("FAIL %s start cycle: outputs %h expected %h", name, obs, 8'h01);
    else passed++;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = (k == poke);
      #1;
      exp_o = {seq[15-4*(k-1) -: 4], 4'b1100};
      checks++;
      if (obs !== exp_o) $display("FAIL %s cycle %0d: outputs %h expected %h", name, k, obs, exp_o);
      else passed++;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h02) $display("FAIL %s done cycle %0d: outputs %h expected %h", name, n+1, obs, 8'h02);
    else passed++;
    checks++;
    if (pp_count !== n[2:0]) $display("FAIL %s pp_count: got %0d expected %0d", name, pp_count, n);
    else passed++;
    checks++;
    if (prod !== exp_prod) $display("FAIL %s product: got %h expected %h", name, prod, exp_prod);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00 || pp_count !== n[2:0])
      $display("FAIL %s idle after done: outputs %h pp_count %0d expected 00 and %0d", name, obs, pp_count, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; op_a = 32'd0; op_b = 32'd0;
    #1;
    checks++;
    if (obs !== 8'h00 || pp_count !== 3'd0)
      $display("FAIL reset_async: outputs %h pp_count %0d expected 00 and 0", obs, pp_count);
    else passed++;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00 || pp_count !== 3'd0)
      $display("FAIL reset_held: outputs %h pp_count %0d expected 00 and 0", obs, pp_count);
    else passed++;
    reset = 1'b1; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 8'h00 || pp_count !== 3'd0)
        $display("FAIL reset_release cycle %0d: outputs %h pp_count %0d expected 00 and 0", k, obs, pp_count);
      else passed++;
    end
  endtask

  task automatic test_full();
    run_op("full", 32'h12345678, 32'h9ABCDEF0, 4, 16'h059E, 64'h0B00EA4E242D2080, 0);
  endtask

  task automatic test_skip();
`ifdef MULT_FAST_SKIP_EN
    run_op("skip_a_msw", 32'h0000FFFF, 32'hFFFF0001, 2, 16'h0500, 64'h0000FFFE0001FFFF, 0);
    run_op("skip_b_msw", 32'h00020003, 32'h00000004, 2, 16'h0900, 64'h000000000008000C, 0);
    run_op("skip_both",  32'd5, 32'd7, 1, 16'h0000, 64'd35, 0);
`else
    run_op("noskip_a_msw", 32'h0000FFFF, 32'hFFFF0001, 4, 16'h059E, 64'h0000FFFE0001FFFF, 0);
    run_op("noskip_b_msw", 32'h00020003, 32'h00000004, 4, 16'h059E, 64'h000000000008000C, 0);
    run_op("noskip_both",  32'd5, 32'd7, 4, 16'h059E, 64'd35, 0);
`endif
  endtask

  task automatic test_start_while_busy();
    run_op("start_in_p01", 32'h12345678, 32'h9ABCDEF0, 4, 16'h059E, 64'h0B00EA4E242D2080, 2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_o;
    logic [15:0] seq;
    int ph;
    seq = 16'h059E;
    @(negedge clk);
    op_a = 32'h12345678; op_b = 32'h9ABCDEF0; start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ph = c % 6;
      if (ph == 0)      exp_o = 8'h01;
      else if (ph == 5) exp_o = 8'h02;
      else              exp_o = {seq[15-4*(ph-1) -: 4], 4'b1100};
      checks++;
      if (obs !== exp_o) $display("FAIL b2b cycle %0d: outputs %h expected %h", c, obs, exp_o);
      else passed++;
      if (ph == 5) begin
        checks++;
        if (prod !== 64'h0B00EA4E242D2080 || pp_count !== 3'd4)
          $display("FAIL b2b result cycle %0d: product %h pp_count %0d expected 0b00ea4e242d2080 and 4", c, prod, pp_count);
        else passed++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) $display("FAIL b2b stop: outputs %h expected 00", obs);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op_a = 32'h12345678; op_b = 32'h9ABCDEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h9C) $display("FAIL midrst in P10: outputs %h expected 9c", obs);
    else passed++;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00 || pp_count !== 3'd0)
      $display("FAIL midrst abort: outputs %h pp_count %0d expected 00 and 0", obs, pp_count);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) $display("FAIL midrst no done: outputs %h expected 00", obs);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 8'h00) $display("FAIL midrst release: outputs %h expected 00", obs);
    else passed++;
    run_op("after_midrst", 32'h12345678, 32'h9ABCDEF0, 4, 16'h059E, 64'h0B00EA4E242D2080, 0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_skip();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
